uart_mem_loader: RTL and testbench
==================================

// Module: uart_mem_loader
// PURPOSE
// - Receive-direction companion to the memory-to-UART dump path. Takes bytes from the UART RX
//   byte stream and writes them as 16-bit words into the 14-bit-addressed SPRAM/BRAM port.
// - Frame format: 2-byte little-endian word count N, then N words, each little-endian
//   (low byte first).
// - Sits between the UART RX core and the memory write port. Used to upload images/tables
//   that the dump path later reads back.
// PARAMETERS
// - DEPTH     8192  max words accepted per frame; also bounds the address range 0..DEPTH-1
// - BASE_ADDR 0     14-bit address of the first word written
// PORTS
// - clk        in   1   system clock, single clock domain
// - rst        in   1   asynchronous, active-low reset
// - start      in   1   one-cycle pulse; arms the loader from IDLE/DONE/ERROR
// - rx_valid   in   1   RX byte available
// - rx_data    in   8   RX byte
// - rx_ready   out  1   loader accepts byte; transfer when rx_valid & rx_ready
// - mem_we     out  1   one-cycle write strobe
// - mem_addr   out  14  write address
// - mem_wdata  out  16  write data {hi, lo}
// - busy       out  1   frame in progress (states LEN_LO..WRITE)
// - done       out  1   level; frame completed without error
// - err        out  1   level; N > DEPTH
// - words      out  14  words written in the current/last frame
// BEHAVIOUR
// - Reset (async, rst==0): state=IDLE; all outputs 0; count, address and byte registers cleared.
// - States: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, DONE, ERROR.
// - rx_ready=1 in LEN_LO, LEN_HI, DAT_LO, DAT_HI and ERROR; 0 elsewhere.
// - IDLE/DONE/ERROR + start: go to LEN_LO; clear done, err, words; addr=BASE_ADDR.
// - start in any other state is ignored.
// - LEN_LO: on transfer, len[7:0]=rx_data -> LEN_HI.
// - LEN_HI: on transfer, len[15:8]=rx_data, then:
//   - N==0 -> DONE;
//   - N>DEPTH -> ERROR (err=1);
//   - else -> DAT_LO.
// - DAT_LO: on transfer, latch lo -> DAT_HI.
// - DAT_HI: on transfer, latch hi -> WRITE.
// - WRITE: exactly one cycle; mem_we=1, mem_wdata={hi,lo}, mem_addr=current addr.
//   Then addr+=1 and words+=1. If words (after increment) == N -> DONE, else -> DAT_LO.
// - Throughput: best case 1 word per 3 cycles; the RX byte rate dominates in practice.
// - mem_addr is registered and valid only while mem_we=1. Address wraps mod 2^14
//   (BASE_ADDR+DEPTH > 16384 wraps silently).
// - ERROR: rx_ready held 1 so stray bytes are drained and discarded; no writes; err held
//   until next start.
// - DONE: done=1; rx_ready=0 (bytes back-pressured); held until next start.
// - rx_valid without a transfer (rx_ready=0) is left pending, never dropped.
// - Reset mid-frame aborts immediately; partially written words stay in memory; no partial
//   word is ever written.
// - Word count compare uses 16-bit N against a 15-bit zero-extended counter; no overflow
//   because N <= DEPTH <= 8192.
// STRUCTURE
// - Shared package/header: state encodings (localparam), frame header size (2 bytes),
//   default DEPTH.
// - Single module; byte-pair packing is inline in the FSM, so no sub-module is needed.
// - Pairs with the RX byte core and with the existing dump module for round-trip checks.
// TESTING
// - Reset mid-DAT_HI -> all outputs 0, state IDLE, no mem_we pulse afterwards.
// - start; bytes 02 00 34 12 78 56 -> writes 0x1234@0, 0x5678@1; done=1, words=2.
// - start; bytes 00 00 -> done=1 within 1 cycle of the 2nd byte, zero mem_we pulses.
// - DEPTH=4; header 05 00 -> err=1, no writes; 3 following bytes accepted and discarded.
// - rx_valid toggled randomly, 100 words -> every word is written exactly once, in order,
//   at addresses BASE_ADDR..BASE_ADDR+99.
// - start pulsed during DAT_LO -> ignored, frame completes normally; BASE_ADDR=16380 with
//   8 words -> address wraps to 0..3.

Source files
------------

// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART-to-memory loader: widths, frame header size,
// default depth and the FSM state encoding.
package uart_mem_loader_pkg;

    localparam int ADDR_W        = 14;
    localparam int DATA_W        = 16;
    localparam int HDR_BYTES     = 2;
    localparam int DEFAULT_DEPTH = 8192;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DAT_LO = 3'd3,
        ST_DAT_HI = 3'd4,
        ST_WRITE  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

endpackage

// File: rtl/uart_mem_loader.sv
// Packs a little-endian byte stream (2-byte word count N, then N words) into 16-bit
// memory writes starting at BASE_ADDR.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int                DEPTH     = DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] words,
    output state_t            dbg_state
);

    // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are both high;
    // an un-accepted byte stays pending on the RX side.
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    state_t            state, state_n;
    logic [15:0]       len_q;
    logic [7:0]        lo_q, hi_q;
    logic [ADDR_W-1:0] addr_q;
    logic [14:0]       cnt_q;
    logic [14:0]       cnt_inc;
    logic [15:0]       len_full;
    logic              xfer;

    assign xfer     = rx_valid & rx_ready;
    assign cnt_inc  = cnt_q + 15'd1;
    assign len_full = {rx_data, len_q[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n  = state;
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            ST_IDLE: if (start) state_n = ST_LEN_LO;
            ST_LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) state_n = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (len_full == 16'd0)                  state_n = ST_DONE;
                    else if ({1'b0, len_full} > DEPTH_LIM)  state_n = ST_ERROR;
                    else                                    state_n = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) state_n = ST_DAT_HI;
            end
            ST_DAT_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) state_n = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                // Counter is one short of N here; compare against the post-increment value.
                if ({1'b0, cnt_inc} == len_q) state_n = ST_DONE;
                else                          state_n = ST_DAT_LO;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_n = ST_LEN_LO;
            end
            ST_ERROR: begin
                rx_ready = 1'b1;
                err      = 1'b1;
                if (start) state_n = ST_LEN_LO;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        addr_q <= BASE_ADDR;
                        cnt_q  <= '0;
                    end
                end
                ST_LEN_LO: if (xfer) len_q[7:0]  <= rx_data;
                ST_LEN_HI: if (xfer) len_q[15:8] <= rx_data;
                ST_DAT_LO: if (xfer) lo_q <= rx_data;
                ST_DAT_HI: if (xfer) hi_q <= rx_data;
                ST_WRITE: begin
                    addr_q <= addr_q + 1'b1;
                    cnt_q  <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = {hi_q, lo_q};
    assign words     = cnt_q[ADDR_W-1:0];
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: three instances (default, DEPTH=4, BASE_ADDR=16380)
// share the RX byte stream; writes of each instance are collected and compared in order.
module tb_uart_mem_loader;
    import uart_mem_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

    logic        ready0, we0, busy0, done0, err0;
    logic [13:0] addr0, words0;
    logic [15:0] wdata0;
    state_t      st0;
    logic        ready1, we1, busy1, done1, err1;
    logic [13:0] addr1, words1;
    logic [15:0] wdata1;
    state_t      st1;
    logic        ready2, we2, busy2, done2, err2;
    logic [13:0] addr2, words2;
    logic [15:0] wdata2;
    state_t      st2;

    int total = 0;
    int bad   = 0;

    logic [29:0] exp_q[$];
    logic [29:0] got0[$];
    logic [29:0] got1[$];
    logic [29:0] got2[$];

    // clock / reset
    always #5 clk = ~clk;

    uart_mem_loader u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(ready0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .busy(busy0), .done(done0), .err(err0), .words(words0), .dbg_state(st0));

    uart_mem_loader #(.DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(ready1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .busy(busy1), .done(done1), .err(err1), .words(words1), .dbg_state(st1));

    uart_mem_loader #(.BASE_ADDR(14'd16380)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(ready2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
        .busy(busy2), .done(done2), .err(err2), .words(words2), .dbg_state(st2));

    // write monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (we0) got0.push_back({addr0, wdata0});
        if (we1) got1.push_back({addr1, wdata1});
        if (we2) got2.push_back({addr2, wdata2});
    end

    function automatic logic cur_ready(input int sel);
        case (sel)
            0:       return ready0;
            1:       return ready1;
            default: return ready2;
        endcase
    endfunction

    // driver tasks; all entered and left on a falling edge
    task automatic pulse_start(input int sel);
        case (sel)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        bit ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cur_ready(sel)) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_byte dut%0d byte=%02h: rx_ready never seen within 50 cycles", sel, b);
        end
    endtask

    task automatic send_word(input int sel, input logic [15:0] w);
        send_byte(sel, w[7:0]);
        send_byte(sel, w[15:8]);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ready0, we0, busy0, done0, err0, words0, addr0, wdata0} !== 49'd0 || st0 !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b done=%b err=%b words=%0d addr=%0d wdata=%h st=%0d, need all 0 / IDLE",
                     ready0, we0, busy0, done0, err0, words0, addr0, wdata0, st0);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        got0.delete();
        exp_q = '{{14'd0, 16'h1234}, {14'd1, 16'h5678}};
        pulse_start(0);
        total++;
        if (busy0 !== 1'b1 || ready0 !== 1'b1) begin
            bad++;
            $display("FAIL basic_armed: busy=%b rx_ready=%b, need 1 1", busy0, ready0);
        end
        send_byte(0, 8'h02); send_byte(0, 8'h00);
        send_word(0, 16'h1234); send_word(0, 16'h5678);
        @(negedge clk);
        total++;
        if (done0 !== 1'b1 || words0 !== 14'd2 || busy0 !== 1'b0 || err0 !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b words=%0d busy=%b err=%b, need 1 2 0 0", done0, words0, busy0, err0);
        end
        total++;
        if (ready0 !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_backpressure: rx_ready=%b, need 0", ready0);
        end
        total++;
        if (got0 !== exp_q) begin
            bad++;
            $display("FAIL basic_writes: got %p, need %p", got0, exp_q);
        end
    endtask

    task automatic test_zero_len();
        got0.delete();
        pulse_start(0);
        total++;
        if (done0 !== 1'b0 || words0 !== 14'd0) begin
            bad++;
            $display("FAIL zero_start_clears: done=%b words=%0d, need 0 0", done0, words0);
        end
        send_byte(0, 8'h00); send_byte(0, 8'h00);
        total++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL zero_done: done=%b busy=%b one cycle after header, need 1 0", done0, busy0);
        end
        repeat (3) @(negedge clk);
        total++;
        if (got0.size() !== 0) begin
            bad++;
            $display("FAIL zero_no_writes: got %0d writes, need 0", got0.size());
        end
    endtask

    task automatic test_error();
        got1.delete();
        pulse_start(1);
        send_byte(1, 8'h05); send_byte(1, 8'h00);
        total++;
        if (err1 !== 1'b1 || done1 !== 1'b0 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
            bad++;
            $display("FAIL error_flag: err=%b done=%b busy=%b rx_ready=%b, need 1 0 0 1", err1, done1, busy1, ready1);
        end
        send_byte(1, 8'hAA); send_byte(1, 8'hBB); send_byte(1, 8'hCC);
        repeat (2) @(negedge clk);
        total++;
        if (err1 !== 1'b1 || got1.size() !== 0 || words1 !== 14'd0) begin
            bad++;
            $display("FAIL error_drain: err=%b writes=%0d words=%0d, need 1 0 0", err1, got1.size(), words1);
        end
    endtask

    task automatic test_depth_limit();
        got1.delete();
        exp_q = '{{14'd0, 16'h0101}, {14'd1, 16'h0202}, {14'd2, 16'h0303}, {14'd3, 16'h0404}};
        pulse_start(1);
        total++;
        if (err1 !== 1'b0) begin
            bad++;
            $display("FAIL depth_start_clears_err: err=%b, need 0", err1);
        end
        send_byte(1, 8'h04); send_byte(1, 8'h00);
        send_word(1, 16'h0101); send_word(1, 16'h0202);
        send_word(1, 16'h0303); send_word(1, 16'h0404);
        @(negedge clk);
        total++;
        if (done1 !== 1'b1 || err1 !== 1'b0 || words1 !== 14'd4) begin
            bad++;
            $display("FAIL depth_exact: done=%b err=%b words=%0d, need 1 0 4", done1, err1, words1);
        end
        total++;
        if (got1 !== exp_q) begin
            bad++;
            $display("FAIL depth_writes: got %p, need %p", got1, exp_q);
        end
    endtask

    task automatic test_start_ignored();
        got0.delete();
        exp_q = '{{14'd0, 16'hBEEF}, {14'd1, 16'hCAFE}};
        pulse_start(0);
        send_byte(0, 8'h02); send_byte(0, 8'h00);
        send_word(0, 16'hBEEF);
        @(negedge clk);
        pulse_start(0);
        total++;
        if (st0 !== ST_DAT_LO || busy0 !== 1'b1) begin
            bad++;
            $display("FAIL start_ignored_state: st=%0d busy=%b, need DAT_LO(3) 1", st0, busy0);
        end
        send_word(0, 16'hCAFE);
        @(negedge clk);
        total++;
        if (done0 !== 1'b1 || words0 !== 14'd2 || got0 !== exp_q) begin
            bad++;
            $display("FAIL start_ignored_frame: done=%b words=%0d got %p, need 1 2 %p", done0, words0, got0, exp_q);
        end
    endtask

    task automatic test_random_valid();
        logic [15:0] w;
        got0.delete();
        exp_q.delete();
        pulse_start(0);
        send_byte(0, 8'd100); send_byte(0, 8'h00);
        for (int i = 0; i < 100; i++) begin
            w = 16'hA000 ^ 16'(i * 16'h0137);
            exp_q.push_back({14'(i), w});
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(0, w[7:0]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(0, w[15:8]);
        end
        @(negedge clk);
        total++;
        if (done0 !== 1'b1 || words0 !== 14'd100) begin
            bad++;
            $display("FAIL random_done: done=%b words=%0d, need 1 100", done0, words0);
        end
        total++;
        if (got0.size() !== 100) begin
            bad++;
            $display("FAIL random_count: got %0d writes, need 100", got0.size());
        end
        for (int i = 0; i < 100 && i < got0.size(); i++) begin
            total++;
            if (got0[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random_word[%0d]: got addr=%0d data=%h, need addr=%0d data=%h",
                         i, got0[i][29:16], got0[i][15:0], exp_q[i][29:16], exp_q[i][15:0]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] w;
        logic [13:0] a;
        got2.delete();
        exp_q.delete();
        pulse_start(2);
        send_byte(2, 8'h08); send_byte(2, 8'h00);
        for (int i = 0; i < 8; i++) begin
            w = 16'h1100 + 16'(i);
            a = (i < 4) ? 14'(16380 + i) : 14'(i - 4);
            exp_q.push_back({a, w});
            send_word(2, w);
        end
        @(negedge clk);
        total++;
        if (done2 !== 1'b1 || words2 !== 14'd8) begin
            bad++;
            $display("FAIL wrap_done: done=%b words=%0d, need 1 8", done2, words2);
        end
        total++;
        if (got2 !== exp_q) begin
            bad++;
            $display("FAIL wrap_addresses: got %p, need %p", got2, exp_q);
        end
    endtask

    task automatic test_reset_mid_frame();
        got0.delete();
        pulse_start(0);
        send_byte(0, 8'h02); send_byte(0, 8'h00);
        send_byte(0, 8'h34);
        total++;
        if (st0 !== ST_DAT_HI) begin
            bad++;
            $display("FAIL reset_mid_setup: st=%0d, need DAT_HI(4)", st0);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({ready0, we0, busy0, done0, err0, words0, addr0, wdata0} !== 49'd0 || st0 !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_mid_outputs: rdy=%b we=%b busy=%b done=%b err=%b words=%0d addr=%0d wdata=%h st=%0d, need all 0 / IDLE",
                     ready0, we0, busy0, done0, err0, words0, addr0, wdata0, st0);
        end
        @(negedge clk);
        rst = 1'b1;
        rx_data  = 8'h12;
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        total++;
        if (got0.size() !== 0 || st0 !== ST_IDLE || ready0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_quiet: writes=%0d st=%0d rx_ready=%b, need 0 IDLE 0", got0.size(), st0, ready0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_error();
        test_depth_limit();
        test_start_ignored();
        test_random_valid();
        test_wrap();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
